// File: rtl/handshake_sync_rx.sv
// Destination side of a 2-phase toggle handshake: synchronizes areq_toggle, captures adata,
// presents it as a valid/ready word and returns back_toggle. Optional macro: HSRX_OVERRUN_DET_EN.
module handshake_sync_rx #(
    parameter int SYNC_STAGE = 3,
    parameter int DATA_W     = 32
) (
    input  logic              bclk,
    input  logic              breset,
    input  logic              areq_toggle,
    input  logic [DATA_W-1:0] adata,
    output logic              bvalid,
    input  logic              bready,
    output logic [DATA_W-1:0] bdata,
    output logic              back_toggle,
    output logic              boverrun
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] sync_chain;

    logic       sync_out;
    logic       req_seen;
    logic       req_edge;
    logic [0:0] state;
    logic [0:0] state_next;
    logic       load;
    logic       accept;
    logic       drop;

    always_ff @(posedge bclk) begin
        if (breset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGE-2:0], areq_toggle};
        end
    end

    assign sync_out = sync_chain[SYNC_STAGE-1];

    always_ff @(posedge bclk) begin
        if (breset) begin
            req_seen <= 1'b0;
        end else begin
            req_seen <= sync_out;
        end
    end

    assign req_edge = sync_out ^ req_seen;

    // An edge that arrives while a word is still held (even in its accept cycle) is lost.
    assign load   = (state == ST_IDLE) && req_edge;
    assign accept = (state == ST_FULL) && bready;
    assign drop   = (state == ST_FULL) && req_edge;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (load)   state_next = ST_FULL;
            ST_FULL: if (accept) state_next = ST_IDLE;
            default:             state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge bclk) begin
        if (breset) begin
            state       <= ST_IDLE;
            bdata       <= '0;
            back_toggle <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                bdata <= adata;
            end
            if (accept) begin
                back_toggle <= ~back_toggle;
            end
        end
    end

    assign bvalid = (state == ST_FULL);

`ifdef HSRX_OVERRUN_DET_EN
    logic overrun_q;

    always_ff @(posedge bclk) begin
        if (breset) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end
    end

    assign boverrun = overrun_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign boverrun    = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_sync_rx.sv
// Self-checking bench for handshake_sync_rx: vector table, corner-case sequences and
// randomized transfers checked against a transaction-level model of the handshake.
module tb_handshake_sync_rx;

    localparam int S_DEF = 3;
`ifdef HSRX_OVERRUN_DET_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    logic        bclk;
    logic        breset;
    logic        areq_toggle;
    logic [31:0] adata;
    logic        bready;

    logic        bvalid, back_toggle, boverrun;
    logic [31:0] bdata;
    logic        bvalid_s2, back_toggle_s2, boverrun_s2;
    logic [31:0] bdata_s2;
    logic        bvalid_s5, back_toggle_s5, boverrun_s5;
    logic [31:0] bdata_s5;

    int total = 0;
    int bad   = 0;

    handshake_sync_rx #(.SYNC_STAGE(S_DEF), .DATA_W(32)) dut (
        .bclk(bclk), .breset(breset), .areq_toggle(areq_toggle), .adata(adata),
        .bvalid(bvalid), .bready(bready), .bdata(bdata),
        .back_toggle(back_toggle), .boverrun(boverrun)
    );

    handshake_sync_rx #(.SYNC_STAGE(2), .DATA_W(32)) dut_s2 (
        .bclk(bclk), .breset(breset), .areq_toggle(areq_toggle), .adata(adata),
        .bvalid(bvalid_s2), .bready(bready), .bdata(bdata_s2),
        .back_toggle(back_toggle_s2), .boverrun(boverrun_s2)
    );

    handshake_sync_rx #(.SYNC_STAGE(5), .DATA_W(32)) dut_s5 (
        .bclk(bclk), .breset(breset), .areq_toggle(areq_toggle), .adata(adata),
        .bvalid(bvalid_s5), .bready(bready), .bdata(bdata_s5),
        .back_toggle(back_toggle_s5), .boverrun(boverrun_s5)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    typedef struct {
        logic [31:0] data;
        logic        early;
        int          hold;
        logic [31:0] exp_data;
        logic        exp_ack;
    } vec_t;

    vec_t vecs[8];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All stimulus changes and all sampling happen on the falling edge.
    task automatic do_reset();
        @(negedge bclk);
        breset = 1'b1; areq_toggle = 1'b0; bready = 1'b0; adata = '0;
        @(negedge bclk);
        @(negedge bclk);
        check_output("reset bvalid", 32'(bvalid), 0);
        check_output("reset bdata", bdata, 0);
        check_output("reset back_toggle", 32'(back_toggle), 0);
        check_output("reset boverrun", 32'(boverrun), 0);
        breset = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge bclk);
            if (bvalid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] data, input logic early, input int hold,
                                  input logic [31:0] exp_data, input logic exp_ack, input string tag);
        int   lat;
        logic stable;
        adata = data; areq_toggle = ~areq_toggle; bready = early;
        wait_valid(lat);
        check_output({tag, " latency"}, 32'(lat), S_DEF + 1);
        check_output({tag, " bdata"}, bdata, exp_data);
        check_output({tag, " ack before accept"}, 32'(back_toggle), 32'(!exp_ack));
        if (!early) begin
            stable = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(negedge bclk);
                if (!bvalid || bdata !== exp_data || back_toggle !== !exp_ack) stable = 1'b0;
            end
            check_output({tag, " hold stable"}, 32'(stable), 1);
            bready = 1'b1;
        end
        @(negedge bclk);
        check_output({tag, " bvalid after accept"}, 32'(bvalid), 0);
        check_output({tag, " ack after accept"}, 32'(back_toggle), 32'(exp_ack));
        bready = 1'b0;
    endtask

    initial begin
        int          lat2, lat3, lat5;
        logic [31:0] d2, d3, d5;
        int          lat;
        logic        quiet;
        logic [31:0] model_q[$];
        logic        ack_model;
        logic [31:0] d;
        logic [31:0] exp;

        vecs[0] = '{32'hA5A5_0001, 1'b0, 10, 32'hA5A5_0001, 1'b1};
        vecs[1] = '{32'hDEAD_BEEF, 1'b1, 0,  32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{32'h0000_0001, 1'b1, 0,  32'h0000_0001, 1'b1};
        vecs[3] = '{32'h0000_0002, 1'b1, 0,  32'h0000_0002, 1'b0};
        vecs[4] = '{32'h0000_0003, 1'b1, 0,  32'h0000_0003, 1'b1};
        vecs[5] = '{32'h0000_0004, 1'b1, 0,  32'h0000_0004, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 1'b0, 3,  32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{32'h0000_0000, 1'b0, 1,  32'h0000_0000, 1'b0};

        breset = 1'b1; areq_toggle = 1'b0; bready = 1'b0; adata = '0;

        // Basic transfer seen by three synchronizer depths at once.
        do_reset();
        adata = 32'hA5A5_0001; areq_toggle = 1'b1; bready = 1'b1;
        lat2 = 0; lat3 = 0; lat5 = 0; d2 = '0; d3 = '0; d5 = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge bclk);
            if (bvalid_s2 && lat2 == 0) begin lat2 = k; d2 = bdata_s2; end
            if (bvalid    && lat3 == 0) begin lat3 = k; d3 = bdata;    end
            if (bvalid_s5 && lat5 == 0) begin lat5 = k; d5 = bdata_s5; end
        end
        check_output("S2 latency", 32'(lat2), 3);
        check_output("S3 latency", 32'(lat3), 4);
        check_output("S5 latency", 32'(lat5), 6);
        check_output("S2 bdata", d2, 32'hA5A5_0001);
        check_output("S3 bdata", d3, 32'hA5A5_0001);
        check_output("S5 bdata", d5, 32'hA5A5_0001);
        check_output("S2 ack", 32'(back_toggle_s2), 1);
        check_output("S3 ack", 32'(back_toggle), 1);
        check_output("S5 ack", 32'(back_toggle_s5), 1);
        check_output("S5 bvalid cleared", 32'(bvalid_s5), 0);
        check_output("aux boverrun", 32'({boverrun_s2, boverrun_s5}), 0);
        bready = 1'b0;

        // Vector table: backpressure, back-to-back 1..4, extreme data values.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].data, vecs[i].early, vecs[i].hold,
                           vecs[i].exp_data, vecs[i].exp_ack, $sformatf("vec%0d", i));
        end
        check_output("table boverrun", 32'(boverrun), 0);

        // Overrun: a second toggle while the first word is still held.
        do_reset();
        adata = 32'h1111_1111; areq_toggle = ~areq_toggle;
        repeat (10) @(negedge bclk);
        check_output("ovr first valid", 32'(bvalid), 1);
        adata = 32'h2222_2222; areq_toggle = ~areq_toggle;
        repeat (10) @(negedge bclk);
        check_output("ovr bdata kept", bdata, 32'h1111_1111);
        check_output("ovr flag", 32'(boverrun), 32'(EXP_OVR));
        bready = 1'b1;
        @(negedge bclk);
        bready = 1'b0;
        check_output("ovr accept ack", 32'(back_toggle), 1);
        quiet = 1'b1;
        repeat (10) begin
            @(negedge bclk);
            if (bvalid) quiet = 1'b0;
        end
        check_output("ovr dropped word", 32'(quiet), 1);
        check_output("ovr flag sticky", 32'(boverrun), 32'(EXP_OVR));

        // Overrun exactly in the accept cycle.
        adata = 32'h3333_3333; areq_toggle = ~areq_toggle;
        wait_valid(lat);
        check_output("post-drop latency", 32'(lat), S_DEF + 1);
        check_output("post-drop bdata", bdata, 32'h3333_3333);
        repeat (3) @(negedge bclk);
        adata = 32'h4444_4444; areq_toggle = ~areq_toggle;
        repeat (S_DEF) @(negedge bclk);
        bready = 1'b1;
        @(negedge bclk);
        bready = 1'b0;
        check_output("accept-cycle drop bvalid", 32'(bvalid), 0);
        check_output("accept-cycle drop ack", 32'(back_toggle), 0);
        quiet = 1'b1;
        repeat (10) begin
            @(negedge bclk);
            if (bvalid || bdata !== 32'h3333_3333) quiet = 1'b0;
        end
        check_output("accept-cycle word lost", 32'(quiet), 1);
        check_output("accept-cycle flag", 32'(boverrun), 32'(EXP_OVR));

        // Reset while a word is held, then a fresh transfer.
        do_reset();
        adata = 32'h5555_AAAA; areq_toggle = ~areq_toggle;
        wait_valid(lat);
        check_output("midrst valid", 32'(bvalid), 1);
        breset = 1'b1; areq_toggle = 1'b0;
        @(negedge bclk);
        check_output("midrst bvalid", 32'(bvalid), 0);
        check_output("midrst bdata", bdata, 0);
        check_output("midrst ack", 32'(back_toggle), 0);
        breset = 1'b0;
        apply_stimulus(32'h0BAD_F00D, 1'b0, 2, 32'h0BAD_F00D, 1'b1, "after reset");

        // Randomized legal sender and consumer against a transaction model.
        do_reset();
        ack_model = 1'b0;
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            model_q.push_back(d);
            repeat ($urandom_range(0, 3)) @(negedge bclk);
            exp = model_q.pop_front();
            ack_model = ~ack_model;
            apply_stimulus(d, 1'($urandom_range(0, 1)), $urandom_range(0, 5), exp, ack_model,
                           $sformatf("rand%0d", i));
        end
        check_output("rand boverrun", 32'(boverrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/handshake_sync_rx.md
HANDSHAKE_SYNC_RX -- requirements
Module: handshake_sync_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGE, default 3, meaning the number of synchronizer flops on the request toggle; legal range is 2 to 8.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the width of the transferred data word.
REQ-003 SHALL have port bclk, input, 1 bit: the single destination clock; all logic is on its rising edge.
REQ-004 SHALL have port breset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port areq_toggle, input, 1 bit: 2-phase request toggle from the source domain, asynchronous to bclk.
REQ-006 SHALL have port adata, input, DATA_W bits: source data, held stable by the sender from the areq_toggle change until the ack toggle returns.
REQ-007 SHALL have port bvalid, output, 1 bit: bdata holds an unaccepted word.
REQ-008 SHALL have port bready, input, 1 bit: the consumer accepts the word when bvalid and bready are both high.
REQ-009 SHALL have port bdata, output, DATA_W bits: the captured word.
REQ-010 SHALL have port back_toggle, output, 1 bit: 2-phase acknowledge to the source domain, driven directly from a flop.
REQ-011 SHALL have port boverrun, output, 1 bit: sticky protocol-error flag.

Function
REQ-012 SHALL pass areq_toggle through a SYNC_STAGE-deep shift chain, with the ASYNC_REG attribute applied to every stage; sync_out is the last stage.
REQ-013 SHALL register sync_out into req_seen every cycle; edge = sync_out XOR req_seen.
REQ-014 SHALL implement a two-state FSM with states IDLE (bvalid=0) and FULL (bvalid=1).
REQ-015 In IDLE with edge=1, SHALL load adata into bdata and go to FULL at the same clock edge.
REQ-016 Latency: an areq_toggle change set up before bclk edge 1 SHALL give bvalid=1 after edge SYNC_STAGE+1 (edge 4 at default).
REQ-017 In FULL with bready=1, SHALL invert back_toggle, clear bvalid and return to IDLE at that clock edge.
REQ-018 In FULL with bready=0, SHALL hold bdata, bvalid and back_toggle unchanged.
REQ-019 bdata SHALL change only on a load (REQ-015) or on reset; it is not cleared on accept.
REQ-020 Overrun case: an edge while in FULL, including in the accept cycle, SHALL be dropped. It SHALL NOT change bdata or the FSM state, and req_seen still updates.
REQ-021 Throughput is at most one word per round trip. A new word SHALL be accepted only after back_toggle has propagated to the sender and the next toggle has re-synchronized.
REQ-022 bready while bvalid=0 SHALL have no effect.

Reset
REQ-023 On breset=1 at a bclk edge, SHALL clear the sync chain, req_seen, back_toggle, bvalid, bdata and boverrun to 0, and set the FSM to IDLE.
REQ-024 Reset mid-transfer SHALL discard any held word without toggling back_toggle; the sender side SHALL be reset in the same reset event (system rule).
REQ-025 A toggle arriving during reset SHALL be ignored. A toggle arriving after reset release SHALL be serviced normally, with its latency measured per REQ-016.

Configuration
REQ-026 Macro HSRX_OVERRUN_DET_EN: when defined, a dropped edge (REQ-020) SHALL set boverrun to 1 on the next edge, and it SHALL stay 1 until breset.
REQ-027 Without HSRX_OVERRUN_DET_EN, boverrun SHALL be tied to constant 0 and no detection logic SHALL be built; REQ-020 drop behaviour is unchanged.

Verification
REQ-028 Basic transfer: after reset, adata=0xA5A5_0001 and areq_toggle 0->1 before edge 1, bready=1 -> bvalid=1 after edge 4 with bdata=0xA5A5_0001; back_toggle=1 and bvalid=0 after edge 5.
REQ-029 Backpressure: as REQ-028 but bready=0 for 10 cycles, then 1 -> bvalid and bdata stable for 10 cycles; back_toggle stays 0 until the accept edge, then 1.
REQ-030 Back-to-back: 4 words 0x1..0x4, sender waits for each back_toggle before toggling again -> exactly 4 accepts in order, back_toggle pattern 1,0,1,0, boverrun=0.
REQ-031 Overrun (macro defined): second toggle while bvalid=1 and bready=0 -> bdata keeps the first word, boverrun=1 until breset; with the macro undefined -> boverrun stays 0.
REQ-032 Reset mid-operation: breset=1 while bvalid=1 -> next edge bvalid=0, bdata=0, back_toggle=0; a fresh toggle after release gives bvalid per REQ-016.
REQ-033 Parameters: repeat REQ-028 with SYNC_STAGE=2 and 5 -> bvalid rises after edge 3 and edge 6 respectively.
